// File: rtl/dds_ctrl_pkg.sv
// Shared definitions for the DDS sequencing controller: wave codes, the
// frequency-index tuning-word table, the configuration record and FSM states.
package dds_pkg;

  localparam logic [2:0] WAVE_SINE   = 3'd0;
  localparam logic [2:0] WAVE_SQUARE = 3'd1;
  localparam logic [2:0] WAVE_TRI    = 3'd2;
  localparam logic [2:0] WAVE_SAWUP  = 3'd3;
  localparam logic [2:0] WAVE_SAWDN  = 3'd4;
  localparam logic [2:0] WAVE_MAX    = WAVE_SAWDN;

  localparam logic [3:0] F_IDX_MAX   = 4'd11;

  typedef struct packed {
    logic [2:0] wave;
    logic [3:0] f;
    logic [1:0] p;
  } cfg_t;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_PEND  = 2'd1,
    S_APPLY = 2'd2
  } state_e;

  // Tuning words for a 32-bit accumulator clocked at 50 MHz.
  function automatic logic [31:0] ftw_of(input logic [3:0] idx);
    logic [31:0] w;
    case (idx)
      4'd0:    w = 32'd85899;
      4'd1:    w = 32'd171799;
      4'd2:    w = 32'd429497;
      4'd3:    w = 32'd858993;
      4'd4:    w = 32'd1717987;
      4'd5:    w = 32'd4294967;
      4'd6:    w = 32'd8589935;
      4'd7:    w = 32'd17179869;
      4'd8:    w = 32'd42949673;
      4'd9:    w = 32'd85899346;
      4'd10:   w = 32'd171798692;
      default: w = 32'd429496730;
    endcase
    return w;
  endfunction

  function automatic cfg_t sanitize_cfg(input logic [2:0] wave,
                                        input logic [3:0] f,
                                        input logic [1:0] p);
    cfg_t c;
    c.wave = (wave > WAVE_MAX) ? WAVE_SINE : wave;
    c.f    = (f > F_IDX_MAX) ? F_IDX_MAX : f;
    c.p    = p;
    return c;
  endfunction

endpackage

// File: rtl/dds_ctrl_if.sv
// Settings and output bundle between the keypad decoder, the controller and
// the waveform ROM/DAC datapath.
interface dds_ctrl_if #(
  parameter int ACC_W  = 32,
  parameter int ADDR_W = 10
);

  logic              en;
  logic [2:0]        wave_type_in;
  logic [3:0]        f_count_in;
  logic [1:0]        p_count_in;
  logic [ADDR_W-1:0] addr_out;
  logic [2:0]        wave_sel_out;
  logic [ACC_W-1:0]  ftw_out;
  logic              sample_valid;
  logic              cfg_pending;
  logic              cfg_applied;

  modport master (
    output en, wave_type_in, f_count_in, p_count_in,
    input  addr_out, wave_sel_out, ftw_out, sample_valid, cfg_pending, cfg_applied
  );

  modport slave (
    input  en, wave_type_in, f_count_in, p_count_in,
    output addr_out, wave_sel_out, ftw_out, sample_valid, cfg_pending, cfg_applied
  );

endinterface

// File: rtl/dds_ctrl_phase_acc.sv
// Phase accumulator: adds the tuning word while enabled and flags the carry
// out as a wrap; a synchronous clear restarts the waveform at phase 0.
module dds_phase_acc #(
  parameter int ACC_W  = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic              clr_i,
  input  logic [ACC_W-1:0]  ftw_i,
  output logic [ADDR_W-1:0] msb_o,
  output logic              wrap_o
);

  logic [ACC_W-1:0] acc_q, acc_d, sum;
  logic             carry;

  assign {carry, sum} = {1'b0, acc_q} + {1'b0, ftw_i};

  // Clear wins over enable so a wave switch always starts from phase 0.
  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign wrap_o = en_i & carry;
  assign msb_o  = acc_q[ACC_W-1 -: ADDR_W];

endmodule

// File: rtl/dds_ctrl.sv
// DDS sequencing controller: holds the active configuration and defers any
// requested change to the next accumulator wrap (or a timeout / stopped run).
module dds_ctrl
  import dds_pkg::*;
#(
  parameter int ACC_W   = 32,
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 1_000_000
) (
  input  logic      clk,
  input  logic      rst_n,
  dds_ctrl_if.slave bus
);

  localparam int               TCNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

  cfg_t              req;
  cfg_t              active_q, active_d;
  cfg_t              shadow_q, shadow_d;
  state_e            state_q, state_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic [ACC_W-1:0]  ftw;
  logic [ADDR_W-1:0] accMsb;
  logic [ADDR_W-1:0] phaseOff;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              valid_q;
  logic              wrap;
  logic              accClr;

  assign req      = sanitize_cfg(bus.wave_type_in, bus.f_count_in, bus.p_count_in);
  assign ftw      = ACC_W'(ftw_of(active_q.f));
  assign phaseOff = ADDR_W'(active_q.p) << (ADDR_W - 2);
  assign addr_d   = accMsb + phaseOff;

  dds_phase_acc #(
    .ACC_W  (ACC_W),
    .ADDR_W (ADDR_W)
  ) u_acc (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (bus.en),
    .clr_i  (accClr),
    .ftw_i  (ftw),
    .msb_o  (accMsb),
    .wrap_o (wrap)
  );

  // A request that returns to the active settings while pending is dropped
  // before any wrap/timeout can apply it.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    tcnt_d   = tcnt_q;
    active_d = active_q;
    accClr   = 1'b0;
    case (state_q)
      S_RUN: begin
        if (req != active_q) begin
          shadow_d = req;
          tcnt_d   = '0;
          state_d  = S_PEND;
        end
      end
      S_PEND: begin
        shadow_d = req;
        tcnt_d   = tcnt_q + TCNT_W'(1);
        if (req == active_q) begin
          state_d = S_RUN;
        end else if (wrap || (tcnt_q == TCNT_LAST) || !bus.en) begin
          state_d = S_APPLY;
        end
      end
      S_APPLY: begin
        active_d = shadow_q;
        accClr   = (shadow_q.wave != active_q.wave);
        state_d  = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_RUN;
      active_q <= '0;
      shadow_q <= '0;
      tcnt_q   <= '0;
      addr_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      shadow_q <= shadow_d;
      tcnt_q   <= tcnt_d;
      addr_q   <= addr_d;
      valid_q  <= bus.en;
    end
  end

  assign bus.addr_out     = addr_q;
  assign bus.wave_sel_out = active_q.wave;
  assign bus.ftw_out      = ftw;
  assign bus.sample_valid = valid_q;
  assign bus.cfg_pending  = (state_q == S_PEND);
  assign bus.cfg_applied  = (state_q == S_APPLY);

endmodule

// File: tb/tb_dds_ctrl.sv
// Directed bench for dds_ctrl with a cycle-level reference model of the
// deferred-configuration rules and per-cycle output comparison.
module tb_dds_ctrl;

  localparam int ACC_W   = 32;
  localparam int ADDR_W  = 10;
  localparam int TIMEOUT = 16;
  localparam longint ACC_MOD  = 64'd1 << ACC_W;
  localparam longint ADDR_MOD = 64'd1 << ADDR_W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #10 clk = ~clk;

  dds_ctrl_if #(.ACC_W(ACC_W), .ADDR_W(ADDR_W)) ifc ();

  dds_ctrl #(
    .ACC_W   (ACC_W),
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  int assertCount = 0;
  int failCount   = 0;

  longint FTW [12] = '{64'd85899, 64'd171799, 64'd429497, 64'd858993,
                       64'd1717987, 64'd4294967, 64'd8589935, 64'd17179869,
                       64'd42949673, 64'd85899346, 64'd171798692, 64'd429496730};

  // Reference model state: phase, active and shadow settings, pending bookkeeping.
  longint mAcc;
  int     mWave, mF, mP;
  int     sWave, sF, sP;
  bit     mPend, mApplied, mValid;
  int     mPendCycles;
  longint mAddr;

  task automatic modelReset();
    mAcc = 0; mWave = 0; mF = 0; mP = 0;
    sWave = 0; sF = 0; sP = 0;
    mPend = 0; mApplied = 0; mValid = 0;
    mPendCycles = 0; mAddr = 0;
  endtask

  task automatic modelStep();
    int     rw, rf, rp;
    bit     e, wrap, reqDiff;
    longint sum;
    e   = ifc.en;
    rw  = (ifc.wave_type_in > 3'd4) ? 0 : int'(ifc.wave_type_in);
    rf  = (ifc.f_count_in > 4'd11) ? 11 : int'(ifc.f_count_in);
    rp  = int'(ifc.p_count_in);
    reqDiff = (rw != mWave) || (rf != mF) || (rp != mP);
    sum  = mAcc + (e ? FTW[mF] : 64'd0);
    wrap = (sum >= ACC_MOD);
    sum  = sum % ACC_MOD;
    mAddr  = ((mAcc >> (ACC_W - ADDR_W)) + (longint'(mP) << (ADDR_W - 2))) % ADDR_MOD;
    mValid = e;
    if (mApplied) begin
      mAcc = (sWave != mWave) ? 64'd0 : sum;
      mWave = sWave; mF = sF; mP = sP;
      mApplied = 0;
    end else begin
      mAcc = sum;
      if (!mPend) begin
        if (reqDiff) begin
          mPend = 1; mPendCycles = 0;
          sWave = rw; sF = rf; sP = rp;
        end
      end else begin
        sWave = rw; sF = rf; sP = rp;
        mPendCycles++;
        if (!reqDiff) begin
          mPend = 0;
        end else if (wrap || (mPendCycles == TIMEOUT) || !e) begin
          mPend = 0;
          mApplied = 1;
        end
      end
    end
  endtask

  initial begin
    modelReset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) modelReset();
      else        modelStep();
    end
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    assertCount++;
    if (actual != expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      checkOutput("model.addr_out",     longint'(ifc.addr_out),     mAddr);
      checkOutput("model.wave_sel_out", longint'(ifc.wave_sel_out), longint'(mWave));
      checkOutput("model.ftw_out",      longint'(ifc.ftw_out),      FTW[mF]);
      checkOutput("model.sample_valid", longint'(ifc.sample_valid), longint'(mValid));
      checkOutput("model.cfg_pending",  longint'(ifc.cfg_pending),  longint'(mPend));
      checkOutput("model.cfg_applied",  longint'(ifc.cfg_applied),  longint'(mApplied));
    end
  end

  task automatic applyStimulus(input logic e, input logic [2:0] w,
                               input logic [3:0] f, input logic [1:0] p);
    ifc.en           = e;
    ifc.wave_type_in = w;
    ifc.f_count_in   = f;
    ifc.p_count_in   = p;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic waitApplied(input int budget, output int pendCount, output bit seen);
    int n;
    pendCount = 0;
    seen      = 0;
    n         = 0;
    while (!seen && n < budget) begin
      tick();
      n++;
      if (ifc.cfg_pending) pendCount++;
      if (ifc.cfg_applied) seen = 1;
    end
  endtask

  initial begin
    int pendCount;
    bit seen;
    bit sawApply;

    applyStimulus(1'b0, 3'd0, 4'd0, 2'd0);
    repeat (3) tick();
    #1 rst_n = 1'b1;
    tick();
    checkOutput("reset.addr",    longint'(ifc.addr_out), 0);
    checkOutput("reset.wave",    longint'(ifc.wave_sel_out), 0);
    checkOutput("reset.ftw",     longint'(ifc.ftw_out), 85899);
    checkOutput("reset.valid",   longint'(ifc.sample_valid), 0);
    checkOutput("reset.pending", longint'(ifc.cfg_pending), 0);
    checkOutput("reset.applied", longint'(ifc.cfg_applied), 0);

    #1 applyStimulus(1'b1, 3'd0, 4'd0, 2'd0);
    tick();
    checkOutput("run.valid", longint'(ifc.sample_valid), 1);
    repeat (3) tick();

    $display("[TB] cancelled change f 0->5->0");
    #1 applyStimulus(1'b1, 3'd0, 4'd5, 2'd0);
    tick();
    checkOutput("cancel.pending", longint'(ifc.cfg_pending), 1);
    #1 applyStimulus(1'b1, 3'd0, 4'd0, 2'd0);
    sawApply = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ifc.cfg_applied) sawApply = 1;
    end
    checkOutput("cancel.no_apply", longint'(sawApply), 0);
    checkOutput("cancel.pending_low", longint'(ifc.cfg_pending), 0);
    checkOutput("cancel.ftw", longint'(ifc.ftw_out), 85899);

    $display("[TB] timeout apply, wave 7 / f 14 sanitised");
    #1 applyStimulus(1'b1, 3'd7, 4'd14, 2'd0);
    waitApplied(40, pendCount, seen);
    checkOutput("timeout.applied", longint'(seen), 1);
    checkOutput("timeout.pend_cycles", longint'(pendCount), 16);
    tick();
    checkOutput("timeout.ftw", longint'(ifc.ftw_out), 429496730);
    checkOutput("timeout.wave", longint'(ifc.wave_sel_out), 0);

    $display("[TB] wrap apply, f 11->9");
    #1 applyStimulus(1'b1, 3'd7, 4'd9, 2'd0);
    waitApplied(40, pendCount, seen);
    checkOutput("wrap.applied", longint'(seen), 1);
    checkOutput("wrap.before_timeout", longint'(pendCount < 16), 1);
    tick();
    checkOutput("wrap.ftw", longint'(ifc.ftw_out), 85899346);
    checkOutput("wrap.wave", longint'(ifc.wave_sel_out), 0);

    $display("[TB] stopped apply, f 9->11 with en low");
    #1 applyStimulus(1'b0, 3'd0, 4'd11, 2'd0);
    tick();
    tick();
    checkOutput("stopped.applied", longint'(ifc.cfg_applied), 1);
    tick();
    checkOutput("stopped.ftw", longint'(ifc.ftw_out), 429496730);
    #1 applyStimulus(1'b1, 3'd0, 4'd11, 2'd0);
    repeat (3) tick();

    $display("[TB] wave 0->2 with phase 180");
    #1 applyStimulus(1'b1, 3'd2, 4'd11, 2'd2);
    waitApplied(40, pendCount, seen);
    checkOutput("wave.applied", longint'(seen), 1);
    checkOutput("wave.before_timeout", longint'(pendCount < 16), 1);
    tick();
    checkOutput("wave.sel", longint'(ifc.wave_sel_out), 2);
    tick();
    checkOutput("wave.addr_phase_only", longint'(ifc.addr_out), 512);
    repeat (4) tick();

    $display("[TB] reset while pending");
    #1 applyStimulus(1'b1, 3'd3, 4'd11, 2'd2);
    tick();
    checkOutput("rst.pending_before", longint'(ifc.cfg_pending), 1);
    #1 rst_n = 1'b0;
    #1 checkOutput("rst.pending_cleared", longint'(ifc.cfg_pending), 0);
    applyStimulus(1'b0, 3'd0, 4'd0, 2'd0);
    tick();
    tick();
    #1 rst_n = 1'b1;
    tick();
    checkOutput("rst.ftw", longint'(ifc.ftw_out), 85899);
    checkOutput("rst.wave", longint'(ifc.wave_sel_out), 0);
    checkOutput("rst.pending", longint'(ifc.cfg_pending), 0);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/dds_ctrl.md
Name: dds_ctrl

Overview:
Sequencing controller between the keypad decoder and the waveform ROM/DAC datapath of the signal generator. It owns a phase accumulator and converts the decoded settings into a phase-accumulator tuning word, a phase offset and a ROM address stream. The settings are wave type, frequency index and phase index. Setting changes are deferred to the next accumulator wrap so the output switches without glitches.

Parameters:
ACC_W, 32, phase accumulator width
ADDR_W, 10, waveform ROM address width (must be ≥ 2)
TIMEOUT, 1_000_000, maximum cycles a pending change waits for a wrap (20 ms at 50 MHz)

Ports:
clk  in  1  system clock, 50 MHz
rst_n  in  1  asynchronous active-low reset
en  in  1  run enable; low freezes the accumulator
wave_type_in  in  3  requested wave: 0 sine, 1 square, 2 triangle, 3 saw-up, 4 saw-down; 5..7 treated as 0
f_count_in  in  4  requested frequency index 0..11; 12..15 clamp to 11
p_count_in  in  2  requested phase index: 0°, 90°, 180°, 270°
addr_out  out  ADDR_W  ROM address including the phase offset
wave_sel_out  out  3  active wave type (sanitised)
ftw_out  out  ACC_W  active tuning word
sample_valid  out  1  addr_out is valid this cycle
cfg_pending  out  1  a requested change is waiting to be applied
cfg_applied  out  1  one-cycle pulse when a new configuration becomes active

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n. All inputs are synchronous to clk.
- Reset values:
  - acc = 0, active cfg = {wave 0, f 0, p 0}, ftw_out = 85899.
  - addr_out = 0, wave_sel_out = 0.
  - sample_valid, cfg_pending, cfg_applied = 0.
  - FSM in S_RUN, timeout counter = 0.
- Request sanitising (combinational): req = {wave > 4 ? 0 : wave, f > 11 ? 11 : f, p}.
- FTW table, f index 0..11 (rounded f·2^32/50e6):
  - 1 kHz 85899; 2 kHz 171799; 5 kHz 429497; 10 kHz 858993
  - 20 kHz 1717987; 50 kHz 4294967; 100 kHz 8589935; 200 kHz 17179869
  - 500 kHz 42949673; 1 MHz 85899346; 2 MHz 171798692; 5 MHz 429496730
- Accumulator: when en = 1, acc <= acc + ftw modulo 2^ACC_W. wrap = carry out of that add. When en = 0, acc holds and wrap = 0.
- Output pipeline (1 cycle latency), registered each cycle:
  - addr_out <= acc[ACC_W-1 -: ADDR_W] + (p_active << (ADDR_W-2)), wrapping mod 2^ADDR_W.
  - sample_valid <= en.
- FSM S_RUN:
  - If req ≠ active: shadow <= req, tcnt <= 0, go to S_PEND.
- FSM S_PEND (cfg_pending = 1):
  - shadow <= req every cycle; the latest request wins. tcnt increments.
  - If req == active: return to S_RUN with no apply (change cancelled).
  - Else if wrap, or tcnt == TIMEOUT-1, or en == 0: go to S_APPLY. Otherwise stay.
- FSM S_APPLY (one cycle):
  - active <= shadow; cfg_applied = 1; go to S_RUN.
  - If shadow.wave ≠ active.wave, acc <= 0 so the new wave starts at phase 0.
  - Otherwise acc advances with the old ftw, keeping frequency and phase changes phase-continuous.
  - The new ftw is used from the next cycle.
- Request changing in the S_APPLY cycle: the applied value is the shadow. S_RUN then detects req ≠ active and re-enters S_PEND the following cycle.
- cfg_pending is high exactly while in S_PEND.
- Reset asserted mid-pending: the change is discarded and the reset configuration is restored.

Decomposition:
- dds_pkg holds:
  - wave-type localparams (WAVE_SINE…WAVE_SAWDN, WAVE_MAX = 4);
  - F_IDX_MAX = 11;
  - FTW lookup function ftw_of(idx);
  - FSM state encodings S_RUN, S_PEND, S_APPLY.
- One sub-module, dds_phase_acc: accumulator with en, synchronous clear, ftw input, wrap output.

Test Plan:
1. Reset → addr_out = 0, wave_sel_out = 0, ftw_out = 85899, sample_valid = 0. One cycle after en = 1, sample_valid = 1 and acc advances by 85899 per cycle.
2. f_count_in 0 → 9 with en = 1 → cfg_pending rises the next cycle and holds until the cycle after wrap. Then cfg_applied pulses, ftw_out = 85899346, wave_sel_out unchanged, and acc is not cleared.
3. wave_type_in 0 → 2 → after wrap, cfg_applied pulses, acc = 0, wave_sel_out = 2. The next addr_out is the phase-offset-only value.
4. p_count_in = 2 with ADDR_W = 10 and acc MSBs = 0 → after apply, addr_out = 512. wave_type_in = 7 and f_count_in = 14 are applied as wave 0 and ftw 429496730.
5. TIMEOUT = 16 with en = 0, then en = 1 and ftw such that no wrap occurs → with en = 0 a change applies 2 cycles after the request. With en = 1 and no wrap it applies after 16 pending cycles.
6. f_count_in 0 → 5 → 0 within the pending window → returns to S_RUN, no cfg_applied pulse, ftw_out stays 85899. Asserting rst_n = 0 while pending clears cfg_pending immediately.
